// File: rtl/nbcac_tx_serializer_5_if.sv
// Word-in / codeword-out bus of the NBCAC transmit serializer.
// master = upstream word source plus bus observer, slave = the serializer.
interface nbcac_tx_serializer_5_if #(
  parameter int NUM_NIBBLES = 4
) ();
  logic [4*NUM_NIBBLES-1:0] din;
  logic                     din_valid;
  logic                     din_ready;
  logic [5:1]               codeout;
  logic                     code_valid;
  logic                     code_sof;
  logic                     busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  codeout,
    input  code_valid,
    input  code_sof,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output codeout,
    output code_valid,
    output code_sof,
    output busy
  );
endinterface

// File: rtl/nbcac_tx_serializer_5.sv
// NBCAC transmit serializer: splits each accepted word into nibbles (LSB
// first), encodes each nibble into a 5-bit crosstalk-avoiding codeword and
// drives it, registered, onto the 5-wire bus. The bus holds its last
// codeword while idle.

// Nibble-to-codeword encoder. The 16 codewords are exactly the 5-bit
// patterns containing neither 010 nor 101, assigned in ascending order.
module nbcac_4di_encoder_core (
  input  logic [3:0] v,
  output logic [5:1] d
);
  // Pure lookup, no state.
  always_comb begin
    d = 5'b00000;
    case (v)
      4'd0:  d = 5'b00000;
      4'd1:  d = 5'b00001;
      4'd2:  d = 5'b00011;
      4'd3:  d = 5'b00110;
      4'd4:  d = 5'b00111;
      4'd5:  d = 5'b01100;
      4'd6:  d = 5'b01110;
      4'd7:  d = 5'b01111;
      4'd8:  d = 5'b10000;
      4'd9:  d = 5'b10001;
      4'd10: d = 5'b10011;
      4'd11: d = 5'b11000;
      4'd12: d = 5'b11001;
      4'd13: d = 5'b11100;
      4'd14: d = 5'b11110;
      4'd15: d = 5'b11111;
      default: d = 5'b00000;
    endcase
  end
endmodule

// CNT_W must satisfy 2**CNT_W >= NUM_NIBBLES, and NUM_NIBBLES >= 2.
module nbcac_tx_serializer_5 #(
  parameter int NUM_NIBBLES = 4,
  parameter int CNT_W       = 2
) (
  input  logic                          clock,
  input  logic                          rst_n,
  nbcac_tx_serializer_5_if.slave        bus
);
  localparam int DW = 4 * NUM_NIBBLES;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NIBBLES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            r_state;
  logic [DW-1:0]     r_sreg;
  logic [CNT_W-1:0]  r_cnt;
  logic [5:1]        r_codeout;
  logic              r_code_valid;
  logic              r_code_sof;
  logic              r_busy;

  logic              w_last;
  logic              w_ready;
  logic              w_xfer;
  logic [5:1]        w_code;

  // The word's final nibble is on the encoder input; a new word may be
  // accepted in the same cycle so words stream without a bubble.
  assign w_last  = (r_state == SEND) && (r_cnt == LAST_CNT);
  assign w_ready = (r_state == IDLE) || w_last;
  assign w_xfer  = bus.din_valid && w_ready;

  nbcac_4di_encoder_core u_enc (
    .v (r_sreg[3:0]),
    .d (w_code)
  );

  // FSM: load words, shift nibbles out, register the codeword and flags.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sreg       <= '0;
      r_cnt        <= '0;
      r_codeout    <= 5'b00000;
      r_code_valid <= 1'b0;
      r_code_sof   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // codeout deliberately untouched so the wires stay quiet
          r_code_valid <= 1'b0;
          r_code_sof   <= 1'b0;
          if (w_xfer) begin
            r_sreg  <= bus.din;
            r_cnt   <= '0;
            r_state <= SEND;
            r_busy  <= 1'b1;
          end
        end
        SEND: begin
          r_codeout    <= w_code;
          r_code_valid <= 1'b1;
          r_code_sof   <= (r_cnt == '0);
          if (w_last) begin
            r_cnt <= '0;
            if (w_xfer) begin
              r_sreg <= bus.din;
            end else begin
              r_sreg  <= {4'b0000, r_sreg[DW-1:4]};
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_sreg <= {4'b0000, r_sreg[DW-1:4]};
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_ready  = w_ready;
  assign bus.codeout    = r_codeout;
  assign bus.code_valid = r_code_valid;
  assign bus.code_sof   = r_code_sof;
  assign bus.busy       = r_busy;
endmodule

// File: doc/nbcac_tx_serializer_5.md
Name: nbcac_tx_serializer_5

Overview:
- Transmit-side stage directly upstream of the 5-wire NBCAC decoder.
- Accepts wide data words over a valid/ready handshake and splits each word into 4-bit nibbles, LSB nibble first.
- Encodes each nibble into a 5-bit NBCAC codeword through the team's nbcac_4di_encoder_core and drives the registered codeword onto the 5-wire bus, one nibble per clock.
- The bus holds its last codeword when idle, so no spurious transitions reach the crosstalk-sensitive wires.

Parameters:
- NUM_NIBBLES, 4, nibbles per input word (>=2); input width = 4*NUM_NIBBLES.
- CNT_W, 2, width of nibble counter; must satisfy 2**CNT_W >= NUM_NIBBLES.

Ports:
- clock  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  4*NUM_NIBBLES  data word; nibble i = din[4i+3:4i].
- din_valid  input  1  din is presented.
- din_ready  output  1  block accepts din this cycle (combinational).
- codeout  output  [5:1]  registered NBCAC codeword driving the bus.
- code_valid  output  1  registered; codeout carries a new nibble this cycle.
- code_sof  output  1  registered; codeout carries nibble 0 of a word.
- busy  output  1  registered; state is SEND.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clock, rst_n).
- Reset values:
  - state = IDLE, shift register = 0, counter = 0.
  - codeout = 5'b00000, code_valid = 0, code_sof = 0, busy = 0.
- Reset mid-word aborts the word immediately. The remaining nibbles are discarded and are not resent after reset release.
- Encoding:
  - One combinational nbcac_4di_encoder_core instance (v = 4-bit data in, d = 5-bit code out) is fed from the shift register's low nibble.
  - Its output is registered into codeout. No other logic touches the codeword bits.
- Handshake:
  - Transfer occurs on a rising edge with din_valid & din_ready.
  - din_ready = (state==IDLE) | (state==SEND & cnt==NUM_NIBBLES-1).
  - din_ready does not depend on din_valid.
  - din must be stable only in the transfer cycle.
- FSM, IDLE:
  - On transfer: load shift register <= din, cnt <= 0, state <= SEND.
  - codeout holds its value, code_valid <= 0, code_sof <= 0.
- FSM, SEND, every cycle:
  - codeout <= enc(sreg[3:0]), code_valid <= 1, code_sof <= (cnt==0).
  - sreg <= sreg >> 4 and cnt <= cnt+1.
- End of word (cnt==NUM_NIBBLES-1):
  - If a transfer occurs in the same cycle: sreg <= din, cnt <= 0, stay in SEND. This is a back-to-back word with no bubble.
  - Otherwise: state <= IDLE, cnt <= 0.
- Latency: a word transferred at edge k puts nibble i on codeout after edge k+1+i, for i = 0..NUM_NIBBLES-1.
- Throughput: one nibble per clock when din_valid is held high. Sustained word rate is 1 per NUM_NIBBLES cycles.
- Idle bus: codeout never changes while code_valid is low. It holds the last codeword sent, or 00000 after reset.
- din_valid asserted while din_ready is low: din is ignored and no state changes. The upstream must hold it.
- busy mirrors (state==SEND) as a register, updated on the same edge as state.

Test Plan:
- Reset, then idle for 10 cycles -> codeout=00000, code_valid=0, code_sof=0, busy=0, din_ready=1 throughout.
- Single word din=16'hA5C3 at edge k, din_valid one cycle:
  - NBCAC_decoder_5 fed from codeout recovers 3,C,5,A after edges k+2..k+5.
  - code_valid high for exactly 4 cycles; code_sof high only for nibble 3.
  - codeout frozen afterwards.
- Back-to-back words 16'h1234 then 16'hFEDC with din_valid held:
  - Second transfer happens in the cycle cnt==3 (din_ready high).
  - 8 consecutive valid cycles decode to 4,3,2,1,C,D,E,F with no bubble.
  - code_sof on the 1st and 5th valid cycles.
- Exhaustive nibble sweep: 4 words cover values 0..15.
  - Every decoded nibble matches.
  - Every codeout equals the encoder-core output for that nibble.
- din_valid high during SEND with cnt<3 -> din_ready=0, din changes ignored, current word decodes intact.
- rst_n asserted asynchronously mid-word, after nibble 1 of 16'h8421:
  - Outputs clear immediately without waiting for a clock edge: codeout=00000, code_valid=0, busy=0.
  - After release, din_ready=1 and no residual nibbles are emitted.
